// File: rtl/game_pkg.sv
// Shared types, widths and default timings for the quiz game blocks.
package game_pkg;

  localparam int unsigned CNT_W           = 8;
  localparam int unsigned SECS_W          = 4;
  localparam int unsigned ANSWER_SECS_DEF = 10;
  localparam int unsigned RESULT_SECS_DEF = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ANSWER = 2'd1,
    RESULT = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

endpackage

// File: rtl/answer_checker_if.sv
// Game-side and player-side signals of the answer checker.
interface answer_checker_if;
  import game_pkg::*;

  logic              tick1Hz;
  logic              answerSig;
  logic [CNT_W-1:0]  numSpecial;
  logic              btnUp;
  logic              btnDown;
  logic              btnSubmit;
  logic [CNT_W-1:0]  guess;
  logic [SECS_W-1:0] timeLeft;
  logic              answering;
  logic              answerDone;
  logic              correct;
  logic [CNT_W-1:0]  score;

  modport master (
    output tick1Hz, answerSig, numSpecial, btnUp, btnDown, btnSubmit,
    input  guess, timeLeft, answering, answerDone, correct, score
  );

  modport slave (
    input  tick1Hz, answerSig, numSpecial, btnUp, btnDown, btnSubmit,
    output guess, timeLeft, answering, answerDone, correct, score
  );

endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector for a debounced button level.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise_c
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= level;
  end

  assign rise_c = level & ~prev;

endmodule

// File: rtl/answer_checker.sv
// Answer window FSM: collects the player's guess, compares it to the symbol
// count, keeps score and shows the result for a fixed number of seconds.
module answer_checker
  import game_pkg::*;
#(
  parameter int unsigned ANSWER_SECS = ANSWER_SECS_DEF,
  parameter int unsigned RESULT_SECS = RESULT_SECS_DEF
) (
  input logic              Clk100M,
  input logic              ResetN,
  answer_checker_if.slave  bus
);

  state_t            state, state_n;
  logic [CNT_W-1:0]  guess, guess_n;
  logic [CNT_W-1:0]  expected, expected_n;
  logic [CNT_W-1:0]  score, score_n;
  logic [SECS_W-1:0] time_left, time_n;
  logic [SECS_W-1:0] res_cnt, res_cnt_n;
  logic              correct, correct_n;
  logic              answer_done, answer_done_n;
  logic              answering, answering_n;
  logic              up_rise_c, down_rise_c, sub_rise_c;

  edge_detect u_up  (.clk(Clk100M), .rst_n(ResetN), .level(bus.btnUp),     .rise_c(up_rise_c));
  edge_detect u_dn  (.clk(Clk100M), .rst_n(ResetN), .level(bus.btnDown),   .rise_c(down_rise_c));
  edge_detect u_sub (.clk(Clk100M), .rst_n(ResetN), .level(bus.btnSubmit), .rise_c(sub_rise_c));

  always_ff @(posedge Clk100M or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      guess       <= '0;
      expected    <= '0;
      score       <= '0;
      time_left   <= '0;
      res_cnt     <= '0;
      correct     <= 1'b0;
      answer_done <= 1'b0;
      answering   <= 1'b0;
    end else begin
      state       <= state_n;
      guess       <= guess_n;
      expected    <= expected_n;
      score       <= score_n;
      time_left   <= time_n;
      res_cnt     <= res_cnt_n;
      correct     <= correct_n;
      answer_done <= answer_done_n;
      answering   <= answering_n;
    end
  end

  // Submit beats a same-cycle timeout; up/down only move the guess while still answering.
  always_comb begin
    state_n       = state;
    guess_n       = guess;
    expected_n    = expected;
    score_n       = score;
    time_n        = time_left;
    res_cnt_n     = res_cnt;
    correct_n     = correct;
    answer_done_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.answerSig) begin
          expected_n = bus.numSpecial;
          guess_n    = '0;
          time_n     = SECS_W'(ANSWER_SECS);
          state_n    = ANSWER;
        end
      end
      ANSWER: begin
        if (sub_rise_c) begin
          correct_n     = (guess == expected);
          if (guess == expected) score_n = sat_inc(score);
          answer_done_n = 1'b1;
          res_cnt_n     = '0;
          state_n       = RESULT;
        end else if (bus.tick1Hz && time_left <= SECS_W'(1)) begin
          correct_n     = 1'b0;
          answer_done_n = 1'b1;
          time_n        = '0;
          res_cnt_n     = '0;
          state_n       = RESULT;
        end else begin
          if (bus.tick1Hz) time_n = time_left - SECS_W'(1);
          if (up_rise_c && !down_rise_c)      guess_n = sat_inc(guess);
          else if (down_rise_c && !up_rise_c) guess_n = sat_dec(guess);
        end
      end
      RESULT: begin
        if (bus.tick1Hz) begin
          if (res_cnt == SECS_W'(RESULT_SECS - 1)) state_n = IDLE;
          else                                     res_cnt_n = res_cnt + SECS_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    answering_n = (state_n == ANSWER);
  end

  assign bus.guess      = guess;
  assign bus.timeLeft   = time_left;
  assign bus.answering  = answering;
  assign bus.answerDone = answer_done;
  assign bus.correct    = correct;
  assign bus.score      = score;

endmodule

// File: tb/tb_answer_checker.sv
// Directed bench for answer_checker: vector table plus timeout, saturation,
// submit-vs-timeout and reset sequences.
module tb_answer_checker;

  logic Clk100M = 1'b0;
  logic ResetN  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_score = 0;

  answer_checker_if bus();

  answer_checker #(.ANSWER_SECS(10), .RESULT_SECS(3)) dut (
    .Clk100M(Clk100M),
    .ResetN (ResetN),
    .bus    (bus)
  );

  always #5 Clk100M = ~Clk100M;

  typedef struct {
    logic [7:0] ns;
    int         ups;
    int         downs;
    int         guess;
    int         correct;
    int         score;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk100M);
    #1;
  endtask

  task automatic press_up(input int n);
    for (int i = 0; i < n; i++) begin
      bus.btnUp = 1'b1; step();
      bus.btnUp = 1'b0; step();
    end
  endtask

  task automatic press_down(input int n);
    for (int i = 0; i < n; i++) begin
      bus.btnDown = 1'b1; step();
      bus.btnDown = 1'b0; step();
    end
  endtask

  task automatic tick();
    bus.tick1Hz = 1'b1; step();
    bus.tick1Hz = 1'b0;
  endtask

  task automatic start(input logic [7:0] ns);
    bus.answerSig  = 1'b1;
    bus.numSpecial = ns;
    step();
    bus.answerSig  = 1'b0;
    bus.numSpecial = 8'd0;
  endtask

  task automatic leave_result();
    for (int i = 0; i < 3; i++) begin
      tick();
      step();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " guess"},      int'(bus.guess), 0);
    check({tag, " timeLeft"},   int'(bus.timeLeft), 0);
    check({tag, " answering"},  int'(bus.answering), 0);
    check({tag, " answerDone"}, int'(bus.answerDone), 0);
    check({tag, " correct"},    int'(bus.correct), 0);
    check({tag, " score"},      int'(bus.score), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{ns: 8'd3, ups: 3, downs: 0, guess: 3, correct: 1, score: 1};
    vecs[1] = '{ns: 8'd2, ups: 1, downs: 0, guess: 1, correct: 0, score: 1};
    vecs[2] = '{ns: 8'd0, ups: 0, downs: 1, guess: 0, correct: 1, score: 2};
    vecs[3] = '{ns: 8'd4, ups: 6, downs: 2, guess: 4, correct: 1, score: 3};
    vecs[4] = '{ns: 8'd7, ups: 2, downs: 5, guess: 0, correct: 0, score: 3};

    bus.tick1Hz = 1'b0; bus.answerSig = 1'b0; bus.numSpecial = 8'd0;
    bus.btnUp = 1'b0; bus.btnDown = 1'b0; bus.btnSubmit = 1'b0;
    step(); step();
    check_reset_values("por");
    ResetN = 1'b1;
    step();

    // Table-driven answer rounds
    for (int v = 0; v < 5; v++) begin
      leave_result();
      start(vecs[v].ns);
      check($sformatf("v%0d answering", v), int'(bus.answering), 1);
      check($sformatf("v%0d timeLeft", v), int'(bus.timeLeft), 10);
      press_up(vecs[v].ups);
      press_down(vecs[v].downs);
      check($sformatf("v%0d guess", v), int'(bus.guess), vecs[v].guess);
      bus.btnSubmit = 1'b1; step();
      bus.btnSubmit = 1'b0;
      check($sformatf("v%0d done", v), int'(bus.answerDone), 1);
      check($sformatf("v%0d correct", v), int'(bus.correct), vecs[v].correct);
      check($sformatf("v%0d score", v), int'(bus.score), vecs[v].score);
      check($sformatf("v%0d answering off", v), int'(bus.answering), 0);
      step();
      check($sformatf("v%0d done pulse", v), int'(bus.answerDone), 0);
      exp_score = vecs[v].score;
    end

    // Timeout after ten ticks, then answerSig ignored during RESULT
    leave_result();
    start(8'd5);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("to timeLeft t%0d", i), int'(bus.timeLeft), 10 - i);
      check($sformatf("to done t%0d", i), int'(bus.answerDone), (i == 10) ? 1 : 0);
      check($sformatf("to answering t%0d", i), int'(bus.answering), (i == 10) ? 0 : 1);
      step();
    end
    check("to correct", int'(bus.correct), 0);
    check("to score", int'(bus.score), exp_score);
    tick(); step();
    tick(); step();
    start(8'd9);
    check("result ignores answerSig", int'(bus.answering), 0);
    tick(); step();
    start(8'd255);
    check("idle after result", int'(bus.answering), 1);

    // Saturation, simultaneous edges, submit discarding a same-cycle up edge
    press_down(1);
    check("sat low", int'(bus.guess), 0);
    press_up(256);
    check("sat high", int'(bus.guess), 255);
    bus.btnUp = 1'b1; bus.btnDown = 1'b1; step();
    check("up+down at 255", int'(bus.guess), 255);
    bus.btnUp = 1'b0; bus.btnDown = 1'b0; step();
    press_down(1);
    check("down to 254", int'(bus.guess), 254);
    bus.btnUp = 1'b1; bus.btnDown = 1'b1; step();
    check("up+down at 254", int'(bus.guess), 254);
    bus.btnUp = 1'b0; bus.btnDown = 1'b0; step();
    bus.btnUp = 1'b1; bus.btnSubmit = 1'b1; step();
    bus.btnUp = 1'b0; bus.btnSubmit = 1'b0;
    check("submit uses old guess", int'(bus.correct), 0);
    check("submit up discarded", int'(bus.guess), 254);
    step();
    press_up(2);
    tick(); step(); tick(); step();
    check("result holds guess", int'(bus.guess), 254);
    check("result holds correct", int'(bus.correct), 0);
    tick(); step();

    // Submit in the same cycle as the final tick
    start(8'd1);
    press_up(1);
    for (int i = 0; i < 9; i++) begin
      tick(); step();
    end
    check("last second", int'(bus.timeLeft), 1);
    bus.tick1Hz = 1'b1; bus.btnSubmit = 1'b1; step();
    bus.tick1Hz = 1'b0; bus.btnSubmit = 1'b0;
    exp_score++;
    check("race done", int'(bus.answerDone), 1);
    check("race correct", int'(bus.correct), 1);
    check("race score", int'(bus.score), exp_score);
    step();
    check("race single pulse a", int'(bus.answerDone), 0);
    step();
    check("race single pulse b", int'(bus.answerDone), 0);

    // Reset in the middle of an answer window, then fresh edges required
    leave_result();
    start(8'd9);
    press_up(2);
    check("pre-reset guess", int'(bus.guess), 2);
    bus.btnUp = 1'b1;
    #2;
    ResetN = 1'b0;
    #1;
    check_reset_values("async");
    step(); step();
    check_reset_values("held");
    ResetN = 1'b1;
    step();
    start(8'd1);
    step(); step();
    check("held button no action", int'(bus.guess), 0);
    bus.btnUp = 1'b0; step();
    press_up(1);
    check("fresh edge acts", int'(bus.guess), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/answer_checker.md
ANSWER_CHECKER -- requirements
Module: answer_checker

Interface
REQ-001 SHALL have parameter ANSWER_SECS, default 10, answer-window length in 1 Hz ticks (range 1-15).
REQ-002 SHALL have parameter RESULT_SECS, default 3, result-display length in 1 Hz ticks (range 1-15).
REQ-003 Clk100M  in  1  sole clock; all logic rising-edge.
REQ-004 ResetN  in  1  reset, asynchronous assert, active-low.
REQ-005 tick1Hz  in  1  one-cycle enable, once per second, synchronous to Clk100M.
REQ-006 answerSig  in  1  one-cycle pulse from the game period: answer window begins.
REQ-007 numSpecial  in  8  count of special symbols; valid in the cycle answerSig is high.
REQ-008 btnUp, btnDown, btnSubmit  in  1 each  debounced player button levels.
REQ-009 guess  out  8  player's current guess.
REQ-010 timeLeft  out  4  seconds remaining in the answer window.
REQ-011 answering  out  1  high while in state ANSWER.
REQ-012 answerDone  out  1  one-cycle pulse when the answer is resolved.
REQ-013 correct  out  1  result of the last resolved answer.
REQ-014 score  out  8  count of correct answers since reset.

Function
REQ-015 SHALL implement FSM states IDLE, ANSWER, RESULT; IDLE after reset.
REQ-016 Each button SHALL act only on its rising edge (0 in previous cycle, 1 in current cycle); held levels SHALL NOT repeat the action.
REQ-017 IDLE + answerSig: latch numSpecial as expected, guess<=0, timeLeft<=ANSWER_SECS, go to ANSWER next cycle.
REQ-018 answerSig SHALL be ignored in ANSWER and RESULT.
REQ-019 ANSWER + up edge only: guess+1, saturating at 255.
REQ-020 ANSWER + down edge only: guess-1, saturating at 0.
REQ-021 ANSWER + up and down edges in the same cycle: guess unchanged.
REQ-022 ANSWER + submit edge: correct<=(guess==expected), using guess before any same-cycle up/down edge, which is discarded; score+1 if correct, saturating at 255; answerDone high next cycle; go to RESULT.
REQ-023 ANSWER + tick1Hz: timeLeft-1; if timeLeft was 1, treat as timeout: correct<=0, answerDone pulse, timeLeft<=0, go to RESULT.
REQ-024 Submit edge and timeout in the same cycle: the submit SHALL win.
REQ-025 RESULT SHALL hold guess and correct stable, count RESULT_SECS ticks, then return to IDLE.
REQ-026 Button edges in IDLE and RESULT SHALL be ignored.
REQ-027 guess, correct and score SHALL retain their values in IDLE until the next answerSig; correct SHALL NOT be cleared.

Reset
REQ-028 On ResetN low, outputs SHALL immediately take these values: FSM=IDLE, guess=0, timeLeft=0, answering=0, answerDone=0, correct=0, score=0, expected=0, edge-detect history=0.
REQ-029 Reset mid-ANSWER or mid-RESULT SHALL abort with no answerDone pulse.
REQ-030 The first action after ResetN deasserts SHALL need a fresh button edge.

Structure
REQ-031 State enum, ANSWER_SECS/RESULT_SECS defaults and 8-bit count width SHALL live in shared package game_pkg.
REQ-032 Rising-edge detection SHALL be sub-module edge_detect, instantiated once per button.

Verification
REQ-033 answerSig with numSpecial=3; 3 up edges; submit -> guess=3, answerDone 1 cycle, correct=1, score 0->1.
REQ-034 numSpecial=2; 1 up edge; submit -> correct=0, score unchanged.
REQ-035 numSpecial=5; no submit; 10 ticks -> timeLeft 10..0, answerDone on 10th tick, correct=0; after 3 more ticks -> IDLE.
REQ-036 Saturation: down edge at guess=0 -> guess stays 0; 256 up edges -> guess=255; up+down same cycle -> guess unchanged.
REQ-037 Submit edge in the same cycle as the final tick, guess==expected -> correct=1, exactly one answerDone.
REQ-038 ResetN low mid-ANSWER -> all outputs at reset values at once, no answerDone; answerSig during RESULT -> ignored.
